// File: rtl/bin_enc_top.sv
// Encoder stage: input FIFO, per-channel 3-tap XNOR-majority convolution along the stream,
// and optional 2:1 OR max-pooling selected by the EC_POOL_EN macro (undefined: one word per tap).

module bin_enc_fifo #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_next;
  logic                  do_wr;
  logic                  do_rd;

  // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
  always_comb begin
    do_rd      = rd_en && (count != '0);
    do_wr      = wr_en && ((count != FULL_CNT) || do_rd);
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
endmodule

module bin_enc_top #(
  parameter int unsigned           DATA_WIDTH = 512,
  parameter int unsigned           FIFO_DEPTH = 16,
  parameter int unsigned           FRAME_LEN  = 64,
  parameter logic [DATA_WIDTH-1:0] W0         = '1,
  parameter logic [DATA_WIDTH-1:0] W1         = '1,
  parameter logic [DATA_WIDTH-1:0] W2         = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_en,
  output logic                  fifo_wfull,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_en,
  output logic                  done
);
  localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_POP = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD, LAST} state_t;

  state_t                state;
  state_t                state_next;
  logic                  pop;
  logic                  y_valid;
  logic                  start_frame;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [CW-1:0]         pop_cnt;
  logic [DATA_WIDTH-1:0] win_prev;
  logic [DATA_WIDTH-1:0] win_cur;
  logic [DATA_WIDTH-1:0] tap_next;
  logic [DATA_WIDTH-1:0] vote_a;
  logic [DATA_WIDTH-1:0] vote_b;
  logic [DATA_WIDTH-1:0] vote_c;
  logic [DATA_WIDTH-1:0] y_word;
`ifdef EC_POOL_EN
  logic [DATA_WIDTH-1:0] y_hold;
  logic                  y_odd;
`endif

  bin_enc_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_en),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_wfull)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The first pop only primes the window; every later pop and the padding step yield one y.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    y_valid     = 1'b0;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          y_valid = (pop_cnt != '0);
          if (pop_cnt == LAST_POP) state_next = PAD;
        end
      end
      PAD: begin
        y_valid    = 1'b1;
        state_next = LAST;
      end
      LAST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tap_next = (state == PAD) ? '0 : fifo_rd_data;
    vote_a   = ~(win_prev ^ W0);
    vote_b   = ~(win_cur  ^ W1);
    vote_c   = ~(tap_next ^ W2);
    y_word   = (vote_a & vote_b) | (vote_a & vote_c) | (vote_b & vote_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt  <= '0;
      win_prev <= '0;
      win_cur  <= '0;
      data_out <= '0;
      out_en   <= 1'b0;
      done     <= 1'b0;
`ifdef EC_POOL_EN
      y_hold   <= '0;
      y_odd    <= 1'b0;
`endif
    end else begin
      out_en <= 1'b0;
      done   <= (state == LAST);
      if (start_frame) begin
        pop_cnt  <= '0;
        win_prev <= '0;
        win_cur  <= '0;
`ifdef EC_POOL_EN
        y_odd    <= 1'b0;
`endif
      end
      if (pop) begin
        pop_cnt  <= pop_cnt + 1'b1;
        win_prev <= win_cur;
        win_cur  <= fifo_rd_data;
      end
      if (y_valid) begin
`ifdef EC_POOL_EN
        y_odd <= ~y_odd;
        if (!y_odd) begin
          y_hold <= y_word;
        end else begin
          data_out <= y_hold | y_word;
          out_en   <= 1'b1;
        end
`else
        data_out <= y_word;
        out_en   <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bin_enc_top.sv
// Randomized self-checking bench for bin_enc_top; two instances (default weights, W1 cleared)
// share stimulus and are compared against a per-channel vote-counting reference model.

module tb_bin_enc_top;
  localparam int unsigned DW    = 512;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FL    = 4;
`ifdef EC_POOL_EN
  localparam int unsigned NOUT  = FL / 2;
`else
  localparam int unsigned NOUT  = FL;
`endif
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] ZERO = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_en;
  logic [DW-1:0] data_in;
  logic          wfull_a, out_en_a, done_a;
  logic          wfull_b, out_en_b, done_b;
  logic [DW-1:0] dout_a, dout_b;

  always #5 clk = ~clk;

  bin_enc_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut_a (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_en(in_en),
    .fifo_wfull(wfull_a), .data_out(dout_a), .out_en(out_en_a), .done(done_a)
  );

  bin_enc_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .W1({DW{1'b0}})) dut_b (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_en(in_en),
    .fifo_wfull(wfull_b), .data_out(dout_b), .out_en(out_en_b), .done(done_b)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] cur_fr [FL];
  logic [DW-1:0] bank [DEPTH+1];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word(input int unsigned density);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = ($urandom_range(0, 99) < density);
    return w;
  endfunction

  // y[t] per channel: count how many taps agree with their weight; at least two agreeing gives 1.
  function automatic logic [DW-1:0] ref_y(input int t, input logic [DW-1:0] w0,
                                           input logic [DW-1:0] w1, input logic [DW-1:0] w2);
    logic [DW-1:0] xm, xc, xp, y;
    int votes;
    xm = ZERO;
    xp = ZERO;
    if (t > 0) xm = cur_fr[t-1];
    if (t < FL - 1) xp = cur_fr[t+1];
    xc = cur_fr[t];
    for (int c = 0; c < DW; c++) begin
      votes = int'(xm[c] == w0[c]) + int'(xc[c] == w1[c]) + int'(xp[c] == w2[c]);
      y[c]  = (votes >= 2);
    end
    return y;
  endfunction

  task automatic build_expected();
    exp_a.delete();
    exp_b.delete();
`ifdef EC_POOL_EN
    for (int k = 0; k < FL / 2; k++) begin
      exp_a.push_back(ref_y(2*k, ONES, ONES, ONES) | ref_y(2*k+1, ONES, ONES, ONES));
      exp_b.push_back(ref_y(2*k, ONES, ZERO, ONES) | ref_y(2*k+1, ONES, ZERO, ONES));
    end
`else
    for (int t = 0; t < FL; t++) begin
      exp_a.push_back(ref_y(t, ONES, ONES, ONES));
      exp_b.push_back(ref_y(t, ONES, ZERO, ONES));
    end
`endif
  endtask

  // mode 0: write frame then start; mode 1: start then trickle words in; mode 2: words already queued.
  task automatic do_frame(input string name, input int mode, input bit extra_start, input bit chk_wfull);
    int na, nb, nd, ndb, last_out, done_cyc, wi;
    bit fin;
    na = 0; nb = 0; nd = 0; ndb = 0; last_out = -10; done_cyc = -10; wi = 0; fin = 0;
    build_expected();
    if (mode == 0) begin
      for (int i = 0; i < FL; i++) begin
        in_en = 1'b1;
        data_in = cur_fr[i];
        @(posedge clk) #1;
      end
      in_en = 1'b0;
    end
    start = 1'b1;
    if (chk_wfull) begin
      @(negedge clk);
      check_eq({name, "_wfull_before_pop"}, DW'(wfull_a), DW'(1));
    end
    @(posedge clk) #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (mode == 1 && wi < FL && $urandom_range(0, 1) == 1) begin
        in_en = 1'b1;
        data_in = cur_fr[wi];
        wi++;
      end else begin
        in_en = 1'b0;
      end
      start = extra_start && (cyc == 3);
      @(negedge clk);
      if (chk_wfull && cyc == 1) check_eq({name, "_wfull_after_pop"}, DW'(wfull_a), DW'(0));
      if (out_en_a) begin
        if (na < int'(NOUT)) check_eq({name, "_dout_a"}, dout_a, exp_a[na]);
        na++;
        last_out = cyc;
      end
      if (out_en_b) begin
        if (nb < int'(NOUT)) check_eq({name, "_dout_b"}, dout_b, exp_b[nb]);
        nb++;
      end
      if (done_b) ndb++;
      if (done_a) begin
        nd++;
        check_eq({name, "_done_timing"}, DW'(cyc), DW'(last_out + 1));
        done_cyc = cyc;
      end
      if (nd > 0 && cyc >= done_cyc + 3) fin = 1;
      @(posedge clk) #1;
    end
    in_en = 1'b0;
    start = 1'b0;
    check_eq({name, "_nout_a"}, DW'(na), DW'(NOUT));
    check_eq({name, "_nout_b"}, DW'(nb), DW'(NOUT));
    check_eq({name, "_ndone_a"}, DW'(nd), DW'(1));
    check_eq({name, "_ndone_b"}, DW'(ndb), DW'(1));
  endtask

  initial begin
    int seen;
    int spurious;
    rst = 1'b1;
    start = 1'b0;
    in_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = rand_word(50);
      @(posedge clk) #1;
    end
    @(negedge clk);
    check_eq("rst_out_en", DW'(out_en_a), DW'(0));
    check_eq("rst_done", DW'(done_a), DW'(0));
    check_eq("rst_wfull", DW'(wfull_a), DW'(0));
    check_eq("rst_dout", dout_a, ZERO);
    rst = 1'b0;
    in_en = 1'b0;
    @(posedge clk) #1;

    for (int i = 0; i < FL; i++) cur_fr[i] = ONES;
    do_frame("all_ones", 0, 0, 0);

    for (int i = 0; i < FL; i++) cur_fr[i] = (i % 2 == 0) ? ONES : ZERO;
    do_frame("alt", 0, 0, 0);

    for (int i = 0; i < DEPTH + 1; i++) bank[i] = rand_word(50);
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_en = 1'b1;
      data_in = bank[i];
      @(negedge clk);
      if (i == DEPTH - 1) check_eq("wfull_early", DW'(wfull_a), DW'(0));
      @(posedge clk) #1;
      if (i >= DEPTH - 1) begin
        @(negedge clk);
        check_eq("wfull_set", DW'(wfull_a), DW'(1));
      end
    end
    in_en = 1'b0;
    for (int f = 0; f < DEPTH / FL; f++) begin
      for (int j = 0; j < FL; j++) cur_fr[j] = bank[f*FL + j];
      do_frame("full", 2, 0, f == 0);
    end

    for (int i = 0; i < FL; i++) cur_fr[i] = rand_word(60);
    for (int i = 0; i < FL; i++) begin
      in_en = 1'b1;
      data_in = cur_fr[i];
      @(posedge clk) #1;
    end
    in_en = 1'b0;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 50 && seen == 0; cyc++) begin
      @(negedge clk);
      if (out_en_a) seen = 1;
    end
    check_eq("midrst_first_out", DW'(seen), DW'(1));
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    spurious = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check_eq("midrst_dout", dout_a, ZERO);
      if (out_en_a || done_a || out_en_b || done_b) spurious++;
    end
    check_eq("midrst_quiet", DW'(spurious), DW'(0));
    for (int i = 0; i < FL; i++) cur_fr[i] = rand_word(50);
    do_frame("after_rst", 1, 0, 0);

    for (int i = 0; i < FL; i++) cur_fr[i] = rand_word(50);
    do_frame("extra_start", 0, 1, 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < FL; i++) cur_fr[i] = rand_word($urandom_range(10, 90));
      do_frame("rand", (n % 2 == 0) ? 1 : 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bin_enc_top.md
Name: bin_enc_top

Overview:
- Encoder-stage top of the binary encoder-decoder network.
- Buffers 512-bit binary feature-map words in an input FIFO.
- On start, processes one frame of FRAME_LEN words through a per-channel 3-tap binary (XNOR-majority) convolution along the stream, then 2:1 OR max-pooling.
- Emits the result words with out_en to the next (decoder) stage.

Parameters:
- DATA_WIDTH, 512, bits per word (one bit per channel).
- FIFO_DEPTH, 16, input FIFO entries; power of 2, minimum 4.
- FRAME_LEN, 64, input words per frame; even, minimum 2.
- W0, {512{1'b1}}, per-channel weight for tap x[t-1].
- W1, {512{1'b1}}, per-channel weight for tap x[t].
- W2, {512{1'b1}}, per-channel weight for tap x[t+1].

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins frame processing.
- data_in  in  DATA_WIDTH  input word.
- in_en  in  1  write strobe for data_in.
- fifo_wfull  out  1  input FIFO full.
- data_out  out  DATA_WIDTH  result word.
- out_en  out  1  data_out valid, one-cycle pulse per word.
- done  out  1  frame-complete pulse.

Behaviour:
- Reset: while rst=1 on an edge, FIFO is emptied, FSM goes to IDLE, window registers and counters clear. data_out=0, out_en=0, done=0, fifo_wfull=0. Reset mid-frame aborts the frame; no done is produced.

FIFO:
- First-word-fall-through.
- A write occurs on an edge where in_en=1 and the FIFO is not full. in_en while full drops the word silently.
- fifo_wfull is registered and equals (count==FIFO_DEPTH).
- A simultaneous read and write while full is allowed: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM IDLE/RUN:
- IDLE: no pops. Words written before start accumulate in the FIFO.
- start=1 in IDLE -> RUN, with the input index cleared. start in RUN is ignored.
- RUN: pop one word per cycle whenever the FIFO is non-empty, until FRAME_LEN words have been popped.
- One internal padding step follows, in the cycle after the final pop.
- After the last output, go back to IDLE.

Convolution:
- Zero padding: x[-1] = x[FRAME_LEN] = 0.
- Per channel c: y[t][c] = MAJ(XNOR(x[t-1][c],W0[c]), XNOR(x[t][c],W1[c]), XNOR(x[t+1][c],W2[c])). MAJ is 1 when at least two of the three inputs are 1.
- y[t] is computed at the pop of x[t+1]. For t=FRAME_LEN-1 it is computed at the padding step.

Pooling:
- Output word k = y[2k] | y[2k+1], for k = 0..FRAME_LEN/2-1.
- Latency: out_en pulses with word k in the cycle after y[2k+1] is computed.
  - k < FRAME_LEN/2-1: the cycle after the pop of input word 2k+2.
  - Last word: the cycle after the padding step.
- Pops stall on an empty FIFO; outputs are produced in order with no gaps inside the pipeline.
- data_out holds its last value when out_en=0.

Completion:
- done is a one-cycle pulse in the cycle after the final out_en. The FSM is in IDLE in that same cycle.
- A new start is accepted from the done cycle onward.

Optional Feature:
- Macro: EC_POOL_EN.
- Defined: pooling as above; FRAME_LEN/2 output words per frame.
- Undefined: pooling removed. data_out = y[t] for each t, giving FRAME_LEN words. out_en pulses the cycle after y[t] is computed. done follows the last word as above.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_en=1 -> out_en=0, done=0, fifo_wfull=0, data_out=0, and no word is stored.
- FRAME_LEN=4, default weights, write 4 all-ones words, then start -> 2 out_en pulses, both data_out=all-ones; done on the cycle after the 2nd pulse.
- FRAME_LEN=4, inputs ones, zeros, ones, zeros -> y = [0s, 1s, 0s, 0s] -> outputs word0=all-ones, word1=all-zeros; the same test without EC_POOL_EN gives 4 words: 0s, 1s, 0s, 0s.
- FIFO_DEPTH=16, no start, 17 writes -> fifo_wfull=1 after the 16th write; the 17th word is dropped. After start, fifo_wfull=0 the cycle after the first pop. Output matches the first 16 words only.
- Mid-frame: apply start, then after 1 output pulse drive rst=1 for 1 cycle -> no further out_en, no done, FIFO empty. A new frame afterwards gives correct results.
- Extra start pulse during RUN is ignored: exactly FRAME_LEN/2 outputs and 1 done. W1=0 with other weights at default and all-ones input -> y = MAJ(1,0,1) = 1 for interior t; outputs all-ones.
